instruction_prefetch_queue: RTL and testbench
=============================================

// Module: instruction_prefetch_queue
// PURPOSE
//   Next-generation instruction register: DEPTH-entry prefetch FIFO in front of the IR.
//   Memory-fetch side pushes words with a valid/ready handshake.
//   Control unit's load pops the head word into ir_out, which is split into opcode/operand fields.
//   Sits between the program memory read port and the control/decode unit of the RISC core.
// PARAMETERS
//   DATAWIDTH     8   instruction word width
//   OPCODE_WIDTH  3   opcode = ir_out[DATAWIDTH-1 -: OPCODE_WIDTH]; operand = remaining LSBs
//   DEPTH_LOG2    2   log2 of queue depth; localparam DEPTH = 1<<DEPTH_LOG2 (min DEPTH_LOG2=1)
// PORTS
//   clk       in   1                          single clock, all state on posedge
//   clr       in   1                          reset, synchronous, active-high
//   in_data   in   DATAWIDTH                  fetched instruction word
//   in_valid  in   1                          in_data valid
//   in_ready  out  1                          queue can accept (= !full)
//   load      in   1                          pop head into IR this cycle
//   ir_out    out  DATAWIDTH                  current instruction register
//   opcode    out  OPCODE_WIDTH               ir_out MSB field (combinational slice)
//   operand   out  DATAWIDTH-OPCODE_WIDTH     ir_out LSB field (combinational slice)
//   ir_valid  out  1                          ir_out holds an instruction loaded by the last load
//   count     out  DEPTH_LOG2+1               queued words, 0..DEPTH
//   flush     in   1                          only when IPQ_FLUSH_EN defined
// BEHAVIOUR
//   Reset (clr=1 at posedge):
//     - ir_out=0, ir_valid=0, count=0, rd/wr pointers=0; in_ready=1 on the following cycle.
//     - Mid-operation reset discards all queued words; push/load that cycle are ignored.
//   Push:
//     - Fires on in_valid && in_ready: word written at wr_ptr, wr_ptr+1 mod DEPTH.
//     - No write when full (in_ready=0); in_data is a don't-care then.
//   Pop:
//     - load && !empty: ir_out<=mem[rd_ptr], ir_valid<=1, rd_ptr+1 mod DEPTH.
//     - load && empty: ir_out holds, ir_valid<=0 (bubble).
//     - !load: ir_out and ir_valid hold.
//   Count:
//     - count +1 on push only, -1 on pop only, unchanged on push and pop together.
//     - Never exceeds DEPTH and never underflows.
//   Pointers: DEPTH_LOG2 bits, natural wrap; full = (count==DEPTH), empty = (count==0).
//   Latency:
//     - Word pushed at edge N is head at N+1.
//     - A load sampled at edge N+1 shows it on ir_out after that edge.
//     - No empty-queue bypass: push and load on an empty queue give a bubble; the word stays queued.
//   Simultaneous push and pop when full: push blocked by in_ready=0; pop proceeds; in_ready=1 next cycle.
//   Simultaneous push and pop when 0<count<DEPTH: both proceed, count unchanged.
//   opcode/operand are pure slices of ir_out, so no extra latency.
// CONFIGURATION
//   IPQ_FLUSH_EN defined:
//     - flush port present; priority clr > flush > push/pop.
//     - flush=1: pointers and count<=0, ir_valid<=0, ir_out held.
//     - Same-cycle push and load dropped; in_ready=1 next cycle.
//     - Used on taken branch/jump.
//   IPQ_FLUSH_EN undefined:
//     - No flush port, no flush logic.
//     - Queue is emptied only by reset or by loads.
// STRUCTURE
//   Shared include risc_defs.vh: default DATAWIDTH, OPCODE_WIDTH, opcode encodings (used by decode).
//   Sub-module ipq_storage: DEPTH x DATAWIDTH register array.
//     - One sync write port (we, waddr, wdata) and one async read port (raddr, rdata).
//     - No reset on storage.
//   Top level holds pointers, count, handshake, IR register and field slicing.
// TESTING
//   T1 reset: clr=1 mid-traffic -> next cycle ir_out=0, ir_valid=0, count=0, in_ready=1.
//   T2 fill: push 8'hA1,A2,A3,A4 (DEPTH=4) -> count=4, in_ready=0; 5th word 8'hFF held off, not stored.
//   T3 drain: 5 consecutive loads -> ir_out A1..A4 with ir_valid=1; 5th load ir_valid=0, ir_out stays A4.
//   T4 fields: load 8'b101_10110 -> opcode=3'b101, operand=5'b10110 in the same cycle ir_out updates.
//   T5 concurrent: count=2, push+load for 6 cycles -> count stays 2, FIFO order preserved across pointer wrap.
//   T6 flush (IPQ_FLUSH_EN): count=3, flush+in_valid+load -> count=0, ir_valid=0, ir_out unchanged, pushed word lost.

Source files
------------

// File: rtl/instruction_prefetch_queue_pkg.sv
// rtl/instruction_prefetch_queue_pkg.sv - shared word geometry and opcode encodings for the prefetch queue
package instruction_prefetch_queue_pkg;

  localparam int IPQ_DATAWIDTH    = 8;
  localparam int IPQ_OPCODE_WIDTH = 3;
  localparam int IPQ_DEPTH_LOG2   = 2;

  // Opcode encodings consumed by the decode stage downstream of the IR.
  typedef enum logic [IPQ_OPCODE_WIDTH-1:0] {
    OP_HLT = 3'b000,
    OP_SKZ = 3'b001,
    OP_ADD = 3'b010,
    OP_AND = 3'b011,
    OP_XOR = 3'b100,
    OP_LDA = 3'b101,
    OP_STO = 3'b110,
    OP_JMP = 3'b111
  } opcode_e;

endpackage

// File: rtl/ipq_storage.sv
// rtl/ipq_storage.sv - DEPTH x DATAWIDTH register array, one sync write port, one async read port
module ipq_storage
  import instruction_prefetch_queue_pkg::*;
#(
  parameter int DATAWIDTH  = IPQ_DATAWIDTH,
  parameter int DEPTH_LOG2 = IPQ_DEPTH_LOG2
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] waddr,
  input  logic [DATAWIDTH-1:0]  wdata,
  input  logic [DEPTH_LOG2-1:0] raddr,
  output logic [DATAWIDTH-1:0]  rdata
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  // Contents are qualified by the queue pointers, so the array carries no reset.
  logic [DATAWIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/instruction_prefetch_queue.sv
// rtl/instruction_prefetch_queue.sv - prefetch FIFO feeding the instruction register
// Define IPQ_FLUSH_EN to add the flush port used to discard the queue on a taken branch.
module instruction_prefetch_queue
  import instruction_prefetch_queue_pkg::*;
#(
  parameter int DATAWIDTH    = IPQ_DATAWIDTH,
  parameter int OPCODE_WIDTH = IPQ_OPCODE_WIDTH,
  parameter int DEPTH_LOG2   = IPQ_DEPTH_LOG2
) (
  input  logic                              clk,
  input  logic                              clr,
`ifdef IPQ_FLUSH_EN
  input  logic                              flush,
`endif
  input  logic [DATAWIDTH-1:0]              in_data,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic                              load,
  output logic [DATAWIDTH-1:0]              ir_out,
  output logic [OPCODE_WIDTH-1:0]           opcode,
  output logic [DATAWIDTH-OPCODE_WIDTH-1:0] operand,
  output logic                              ir_valid,
  output logic [DEPTH_LOG2:0]               count
);

  localparam int                DEPTH     = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] DEPTH_CNT = (DEPTH_LOG2+1)'(DEPTH);

  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [DATAWIDTH-1:0]  head_data;
  logic                  full;
  logic                  empty;
  logic                  push;
  logic                  pop;
  logic                  hold_off;

  assign full     = (count == DEPTH_CNT);
  assign empty    = (count == '0);
  assign in_ready = !full;
  assign push     = in_valid && in_ready;
  assign pop      = load && !empty;

`ifdef IPQ_FLUSH_EN
  assign hold_off = clr || flush;
`else
  assign hold_off = clr;
`endif

  ipq_storage #(
    .DATAWIDTH  (DATAWIDTH),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_storage (
    .clk   (clk),
    .we    (push && !hold_off),
    .waddr (wr_ptr),
    .wdata (in_data),
    .raddr (rd_ptr),
    .rdata (head_data)
  );

  always_ff @(posedge clk) begin
    if (clr) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      ir_out   <= '0;
      ir_valid <= 1'b0;
    end
`ifdef IPQ_FLUSH_EN
    else if (flush) begin
      // IR keeps its last word; only the speculative queue contents are dropped.
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      ir_valid <= 1'b0;
    end
`endif
    else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (load) begin
        // A load on an empty queue is a bubble: IR holds but is marked stale.
        ir_valid <= pop;
        if (pop) begin
          ir_out <= head_data;
          rd_ptr <= rd_ptr + 1'b1;
        end
      end
      if (push && !pop) begin
        count <= count + 1'b1;
      end else if (pop && !push) begin
        count <= count - 1'b1;
      end
    end
  end

  assign opcode  = ir_out[DATAWIDTH-1 -: OPCODE_WIDTH];
  assign operand = ir_out[DATAWIDTH-OPCODE_WIDTH-1:0];

endmodule

// File: tb/tb_instruction_prefetch_queue.sv
// tb/tb_instruction_prefetch_queue.sv - directed bench for instruction_prefetch_queue (DEPTH=4, 8-bit words)
module tb_instruction_prefetch_queue;

  logic       clk = 1'b0;
  logic       clr;
  logic       flush;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       load;
  logic [7:0] ir_out;
  logic [2:0] opcode;
  logic [4:0] operand;
  logic       ir_valid;
  logic [2:0] count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  instruction_prefetch_queue dut (
    .clk      (clk),
    .clr      (clr),
`ifdef IPQ_FLUSH_EN
    .flush    (flush),
`endif
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .load     (load),
    .ir_out   (ir_out),
    .opcode   (opcode),
    .operand  (operand),
    .ir_valid (ir_valid),
    .count    (count)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [7:0] d, input logic l);
    in_valid = v;
    in_data  = d;
    load     = l;
    step();
  endtask

  logic [7:0] exp_w;

  initial begin
    clr = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; load = 1'b0;
    step();
    chk("rst_ir_out", ir_out, 0);
    chk("rst_ir_valid", ir_valid, 0);
    chk("rst_count", count, 0);
    chk("rst_in_ready", in_ready, 1);
    clr = 1'b0;

    // Fill to DEPTH, then offer a fifth word that must be held off.
    for (int i = 0; i < 4; i++) begin
      exp_w = 8'hA1 + 8'(i);
      drive(1'b1, exp_w, 1'b0);
    end
    chk("fill_count", count, 4);
    chk("fill_in_ready", in_ready, 0);
    drive(1'b1, 8'hFF, 1'b0);
    chk("full_count_hold", count, 4);

    // Drain with five loads; the fifth is a bubble.
    for (int i = 0; i < 4; i++) begin
      exp_w = 8'hA1 + 8'(i);
      drive(1'b0, 8'h00, 1'b1);
      chk($sformatf("drain_ir_%0d", i), ir_out, 32'(exp_w));
      chk($sformatf("drain_valid_%0d", i), ir_valid, 1);
      chk($sformatf("drain_count_%0d", i), count, 32'(3 - i));
    end
    drive(1'b0, 8'h00, 1'b1);
    chk("bubble_valid", ir_valid, 0);
    chk("bubble_ir_hold", ir_out, 8'hA4);
    chk("bubble_count", count, 0);

    // Push and load together on empty queue: no bypass, word stays queued.
    drive(1'b1, 8'b101_10110, 1'b1);
    chk("nobypass_valid", ir_valid, 0);
    chk("nobypass_ir", ir_out, 8'hA4);
    chk("nobypass_count", count, 1);
    drive(1'b0, 8'h00, 1'b1);
    chk("field_ir", ir_out, 8'b101_10110);
    chk("field_opcode", opcode, 3'b101);
    chk("field_operand", operand, 5'b10110);
    chk("field_valid", ir_valid, 1);

    // Steady-state push+pop at count=2 across pointer wrap.
    drive(1'b1, 8'h11, 1'b0);
    drive(1'b1, 8'h22, 1'b0);
    chk("conc_pre_count", count, 2);
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 8'h33 + 8'(i * 8'h11), 1'b1);
      exp_w = 8'h11 + 8'(i * 8'h11);
      chk($sformatf("conc_ir_%0d", i), ir_out, 32'(exp_w));
      chk($sformatf("conc_count_%0d", i), count, 2);
    end
    drive(1'b0, 8'h00, 1'b1);
    chk("conc_tail0", ir_out, 8'h77);
    drive(1'b0, 8'h00, 1'b1);
    chk("conc_tail1", ir_out, 8'h88);
    chk("conc_empty", count, 0);

    // Full queue with push and load: pop proceeds, push blocked.
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 8'hB0 + 8'(i), 1'b0);
    end
    drive(1'b1, 8'hEE, 1'b1);
    chk("fullpp_ir", ir_out, 8'hB0);
    chk("fullpp_count", count, 3);
    chk("fullpp_in_ready", in_ready, 1);

    // Mid-traffic reset with push and load asserted.
    clr = 1'b1;
    drive(1'b1, 8'h55, 1'b1);
    clr = 1'b0;
    chk("midrst_ir_out", ir_out, 0);
    chk("midrst_ir_valid", ir_valid, 0);
    chk("midrst_count", count, 0);
    chk("midrst_in_ready", in_ready, 1);
    drive(1'b0, 8'h00, 1'b1);
    chk("midrst_empty_bubble", ir_valid, 0);

`ifdef IPQ_FLUSH_EN
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 8'hC1 + 8'(i), 1'b0);
    end
    drive(1'b0, 8'h00, 1'b1);
    chk("fl_pre_count", count, 3);
    flush = 1'b1;
    drive(1'b1, 8'hDD, 1'b1);
    flush = 1'b0;
    chk("fl_count", count, 0);
    chk("fl_valid", ir_valid, 0);
    chk("fl_ir_hold", ir_out, 8'hC1);
    chk("fl_in_ready", in_ready, 1);
    drive(1'b1, 8'hD1, 1'b0);
    drive(1'b0, 8'h00, 1'b1);
    chk("fl_after_ir", ir_out, 8'hD1);
    chk("fl_after_count", count, 0);
`endif

    in_valid = 1'b0;
    load = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
